// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: a main entry plus a skid entry, valid/ready handshake, and a flush that injects bubbles.
// Optional stall counter: define PIPE_STAGE_STALL_CNT_EN to add the stall_cnt output.
module pipe_stage_reg #(
  parameter int unsigned          PC_W       = 32,
  parameter int unsigned          PAYLOAD_W  = 32,
  parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [PAYLOAD_W-1:0] out_payload
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  logic                 main_v;
  logic [PC_W-1:0]      main_pc;
  logic [PAYLOAD_W-1:0] main_payload;
  logic                 skid_v;
  logic [PC_W-1:0]      skid_pc;
  logic [PAYLOAD_W-1:0] skid_payload;

  logic accept;
  logic drain;

  // in_ready depends only on the skid flop, so out_ready never reaches it combinationally.
  assign in_ready  = ~skid_v;
  assign accept    = in_valid & ~skid_v;
  assign drain     = main_v & out_ready;

  assign out_valid   = main_v;
  assign out_pc      = main_v ? main_pc : '0;
  assign out_payload = main_v ? main_payload : BUBBLE_VAL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v       <= 1'b0;
      main_pc      <= '0;
      main_payload <= BUBBLE_VAL;
      skid_v       <= 1'b0;
      skid_pc      <= '0;
      skid_payload <= BUBBLE_VAL;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || drain) begin
      if (skid_v) begin
        // The skid entry is older than anything on the input, so it moves up first.
        main_v       <= 1'b1;
        main_pc      <= skid_pc;
        main_payload <= skid_payload;
        skid_v       <= accept;
        if (accept) begin
          skid_pc      <= in_pc;
          skid_payload <= in_payload;
        end
      end else begin
        main_v <= accept;
        if (accept) begin
          main_pc      <= in_pc;
          main_payload <= in_payload;
        end
      end
    end else if (accept) begin
      skid_v       <= 1'b1;
      skid_pc      <= in_pc;
      skid_payload <= in_payload;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // A flush cycle is not counted as a stall because out_ready is ignored then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (main_v && !out_ready && !flush && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: reset, streaming, back-pressure, flush, wide parameters and optional stall counter.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_payload;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_payload;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic        w_in_valid;
  logic        w_in_ready;
  logic [15:0] w_in_pc;
  logic [71:0] w_in_payload;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [15:0] w_out_pc;
  logic [71:0] w_out_payload;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_payload (out_payload)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  pipe_stage_reg #(.PC_W(16), .PAYLOAD_W(72), .BUBBLE_VAL(72'h13)) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (w_in_valid),
    .in_ready    (w_in_ready),
    .in_pc       (w_in_pc),
    .in_payload  (w_in_payload),
    .out_valid   (w_out_valid),
    .out_ready   (w_out_ready),
    .out_pc      (w_out_pc),
    .out_payload (w_out_payload)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt   ()
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests_run++;
    if ({out_valid, out_pc, out_payload, in_ready} !== {1'b0, 32'h0, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL reset_initial: got v=%b pc=%h pl=%h rdy=%b, want v=0 pc=0 pl=0 rdy=1",
               out_valid, out_pc, out_payload, in_ready);
    end
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_pc = 32'h8; in_payload = 32'hDEAD0001;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_payload, in_ready} !== {1'b0, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL reset_async: got v=%b pl=%h rdy=%b, want v=0 pl=0 rdy=1",
               out_valid, out_payload, in_ready);
    end
    step();
    rst_n = 1'b1;
    in_pc = 32'h4; in_payload = 32'h00A00093;
    step();
    tests_run++;
    if ({out_valid, out_pc, out_payload} !== {1'b1, 32'h4, 32'h00A00093}) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_entry: got v=%b pc=%h pl=%h, want v=1 pc=4 pl=00a00093",
               out_valid, out_pc, out_payload);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tests_run++;
      if (i > 0 && {out_valid, out_pc, out_payload, in_ready} !==
                   {1'b1, 32'(4 * i), 32'hA0000000 + 32'(i - 1), 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL stream_%0d: got v=%b pc=%h pl=%h rdy=%b, want v=1 pc=%h pl=%h rdy=1",
                 i, out_valid, out_pc, out_payload, in_ready, 32'(4 * i), 32'hA0000000 + 32'(i - 1));
      end else if (i == 0 && in_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stream_ready: got rdy=%b, want 1", in_ready);
      end
      in_valid   = (i < 8);
      in_pc      = 32'(4 * (i + 1));
      in_payload = 32'hA0000000 + 32'(i);
      step();
    end
    tests_run++;
    if ({out_valid, out_pc, out_payload} !== {1'b0, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL stream_idle: got v=%b pc=%h pl=%h, want v=0 pc=0 pl=0",
               out_valid, out_pc, out_payload);
    end
  endtask

  // Leaves A in main and B in skid with out_ready low.
  task automatic load_two(input logic [31:0] a_pl, input logic [31:0] b_pl);
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h100; in_payload = a_pl;
    step();
    in_pc = 32'h104; in_payload = b_pl;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    load_two(32'hAAAA0001, 32'hBBBB0002);
    tests_run++;
    if ({out_valid, out_pc, out_payload, in_ready} !== {1'b1, 32'h100, 32'hAAAA0001, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL bp_hold_a: got v=%b pc=%h pl=%h rdy=%b, want v=1 pc=100 pl=aaaa0001 rdy=0",
               out_valid, out_pc, out_payload, in_ready);
    end
    step();
    tests_run++;
    if ({out_valid, out_pc, out_payload, in_ready} !== {1'b1, 32'h100, 32'hAAAA0001, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL bp_stable_a: got v=%b pc=%h pl=%h rdy=%b, want v=1 pc=100 pl=aaaa0001 rdy=0",
               out_valid, out_pc, out_payload, in_ready);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if ({out_valid, out_pc, out_payload, in_ready} !== {1'b1, 32'h104, 32'hBBBB0002, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL bp_then_b: got v=%b pc=%h pl=%h rdy=%b, want v=1 pc=104 pl=bbbb0002 rdy=1",
               out_valid, out_pc, out_payload, in_ready);
    end
    step();
    tests_run++;
    if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL bp_empty: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    load_two(32'hAAAA1111, 32'hBBBB2222);
    in_valid = 1'b1; in_pc = 32'h108; in_payload = 32'hCCCC3333;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_pc, out_payload, in_ready} !== {1'b0, 32'h0, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL flush_bubble: got v=%b pc=%h pl=%h rdy=%b, want v=0 pc=0 pl=0 rdy=1",
               out_valid, out_pc, out_payload, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL flush_no_leak_%0d: got v=%b pl=%h, want v=0", i, out_valid, out_payload);
      end
    end
    // An entry offered while in_ready is high must still be dropped by flush.
    in_valid = 1'b1; in_pc = 32'h200; in_payload = 32'hDDDD4444; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL flush_drop_input: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_wide();
    tests_run++;
    if ({w_out_valid, w_out_pc, w_out_payload} !== {1'b0, 16'h0, 72'h13}) begin
      tests_failed++;
      $display("[TB] FAIL wide_idle: got v=%b pc=%h pl=%h, want v=0 pc=0 pl=13",
               w_out_valid, w_out_pc, w_out_payload);
    end
    w_out_ready = 1'b1;
    w_in_valid = 1'b1; w_in_pc = 16'h1234; w_in_payload = 72'hDE_ADBE_EF01_2345_6789;
    step();
    w_in_valid = 1'b0;
    tests_run++;
    if ({w_out_valid, w_out_pc, w_out_payload} !== {1'b1, 16'h1234, 72'hDE_ADBE_EF01_2345_6789}) begin
      tests_failed++;
      $display("[TB] FAIL wide_pass: got v=%b pc=%h pl=%h, want v=1 pc=1234 pl=deadbeef0123456789",
               w_out_valid, w_out_pc, w_out_payload);
    end
    step();
    tests_run++;
    if ({w_out_valid, w_out_payload} !== {1'b0, 72'h13}) begin
      tests_failed++;
      $display("[TB] FAIL wide_bubble: got v=%b pl=%h, want v=0 pl=13", w_out_valid, w_out_payload);
    end
  endtask

`ifdef PIPE_STAGE_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h300; in_payload = 32'h12345678;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    tests_run++;
    if (stall_cnt !== 16'd5) begin
      tests_failed++;
      $display("[TB] FAIL stall_cnt_5: got %0d, want 5", stall_cnt);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests_run++;
    if (stall_cnt !== 16'd5) begin
      tests_failed++;
      $display("[TB] FAIL stall_cnt_flush: got %0d, want 5", stall_cnt);
    end
    force dut.stall_cnt_q = 16'hFFFE;
    step();
    release dut.stall_cnt_q;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    tests_run++;
    if (stall_cnt !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL stall_cnt_sat: got %h, want ffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_payload = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_pc = '0; w_in_payload = '0; w_out_ready = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_wide();
`ifdef PIPE_STAGE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
